// File: rtl/fm_ctrl_sequencer.sv
// fm_ctrl_sequencer: clock-enable divider and coefficient streamer for the
// stereo FM modulator datapath. Coefficients are double-buffered (shadow ->
// active) and the active set is streamed MSB first once per 48 kHz frame.
`timescale 1ns/1ps
module fm_ctrl_sequencer #(
    parameter int CLK_DIV = 512,
    parameter int COEF_W  = 18
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_sel,
    input  logic [COEF_W-1:0] cfg_data,
    output logic              cfg_pending,
    output logic              clken192kHz,
    output logic              clken48kHz,
    output logic [1:0]        phase,
    output logic              coef_sync,
    output logic              Ks,
    output logic              Kd,
    output logic              Kp,
    output logic              Kf
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = (COEF_W > 1) ? $clog2(COEF_W) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_STREAM
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [1:0]         phase_q;
    logic [BIT_W-1:0]   bit_q;
    logic [COEF_W-1:0]  shadow_q [4];
    logic [COEF_W-1:0]  active_q [4];
    logic               pending_q;

    logic               running;
    logic               tick192;
    logic               tick48;
    logic               boundary;
    logic               last_bit;
    logic [BIT_W-1:0]   bit_idx;

    assign running  = (state_q != ST_IDLE);
    assign tick192  = running && (cnt_q == CNT_W'(CLK_DIV - 1));
    assign tick48   = tick192 && (phase_q == 2'd3);
    // A boundary only commits while the sequencer stays enabled; dropping
    // enable on that very cycle leaves the pending update for the next run.
    assign boundary = tick48 && (state_q == ST_RUN) && enable;
    assign last_bit = (bit_q == BIT_W'(COEF_W - 1));
    assign bit_idx  = BIT_W'(COEF_W - 1) - bit_q;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: enable low always wins and forces IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!enable)       state_d = ST_IDLE;
                else if (boundary) state_d = ST_STREAM;
            end
            ST_STREAM: begin
                if (!enable)       state_d = ST_IDLE;
                else if (last_bit) state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Divider, sub-frame phase and stream bit counter; all held at zero in IDLE
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            phase_q <= '0;
            bit_q   <= '0;
        end else if (!enable || state_q == ST_IDLE) begin
            cnt_q   <= '0;
            phase_q <= '0;
            bit_q   <= '0;
        end else begin
            if (tick192) begin
                cnt_q   <= '0;
                phase_q <= phase_q + 2'd1;
            end else begin
                cnt_q   <= cnt_q + CNT_W'(1);
            end
            if (state_q == ST_STREAM && !last_bit) begin
                bit_q <= bit_q + BIT_W'(1);
            end else begin
                bit_q <= '0;
            end
        end
    end

    // Shadow writes, frame-boundary transfer to active set, pending flag.
    // A write coinciding with the boundary lands in shadow only, so the
    // transfer uses the pre-edge shadow and pending remains set.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
            pending_q <= 1'b0;
        end else begin
            if (cfg_we) begin
                shadow_q[cfg_sel] <= cfg_data;
            end
            if (boundary) begin
                for (int i = 0; i < 4; i++) begin
                    active_q[i] <= shadow_q[i];
                end
                pending_q <= cfg_we;
            end else if (cfg_we) begin
                pending_q <= 1'b1;
            end
        end
    end

    // Output decode: everything derives from registered state, so an
    // asynchronous reset zeroes the outputs without waiting for an edge
    always_comb begin
        clken192kHz = tick192;
        clken48kHz  = tick48;
        phase       = phase_q;
        cfg_pending = pending_q;
        coef_sync   = 1'b0;
        Ks          = 1'b0;
        Kd          = 1'b0;
        Kp          = 1'b0;
        Kf          = 1'b0;
        if (state_q == ST_STREAM) begin
            coef_sync = (bit_q == '0);
            Ks        = active_q[0][bit_idx];
            Kd        = active_q[1][bit_idx];
            Kp        = active_q[2][bit_idx];
            Kf        = active_q[3][bit_idx];
        end
    end

endmodule

// File: tb/tb_fm_ctrl_sequencer.sv
// Bench for fm_ctrl_sequencer with CLK_DIV=8, COEF_W=18. Cycle k is the
// clock period that begins at the k-th edge after enable is first seen high.
`timescale 1ns/1ps
module tb_fm_ctrl_sequencer;

    localparam int CD = 8;
    localparam int CW = 18;
    localparam int FR = 4 * CD;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic          cfg_we = 1'b0;
    logic [1:0]    cfg_sel = 2'd0;
    logic [CW-1:0] cfg_data = '0;
    logic          cfg_pending;
    logic          clken192kHz;
    logic          clken48kHz;
    logic [1:0]    phase;
    logic          coef_sync;
    logic          Ks, Kd, Kp, Kf;

    fm_ctrl_sequencer #(.CLK_DIV(CD), .COEF_W(CW)) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .cfg_we      (cfg_we),
        .cfg_sel     (cfg_sel),
        .cfg_data    (cfg_data),
        .cfg_pending (cfg_pending),
        .clken192kHz (clken192kHz),
        .clken48kHz  (clken48kHz),
        .phase       (phase),
        .coef_sync   (coef_sync),
        .Ks          (Ks),
        .Kd          (Kd),
        .Kp          (Kp),
        .Kf          (Kf)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic       c192;
        logic       c48;
        logic [1:0] ph;
        logic       sync;
        logic       ks;
        logic       kd;
        logic       kp;
        logic       kf;
    } out_t;

    typedef struct {
        int   cyc;
        out_t exp;
    } vec_t;

    int total = 0;
    int bad   = 0;
    int scen  = 0;

    vec_t          tv [8];
    logic [CW-1:0] fk [0:3][0:7];   // expected coefficient per (coef, frame)
    out_t          exp_q [$];

    function automatic out_t mk(input logic c192, input logic c48,
                                input logic [1:0] ph, input logic sync);
        out_t o;
        o      = '0;
        o.c192 = c192;
        o.c48  = c48;
        o.ph   = ph;
        o.sync = sync;
        return o;
    endfunction

    function automatic out_t dut_out();
        out_t o;
        o.c192 = clken192kHz;
        o.c48  = clken48kHz;
        o.ph   = phase;
        o.sync = coef_sync;
        o.ks   = Ks;
        o.kd   = Kd;
        o.kp   = Kp;
        o.kf   = Kf;
        return o;
    endfunction

    // Expected outputs in cycle k of an uninterrupted run
    function automatic out_t model(input int k);
        out_t o;
        int   j;
        int   f;
        o      = '0;
        j      = k % FR;
        f      = k / FR;
        o.c192 = ((k % CD) == CD - 1);
        o.c48  = (j == FR - 1);
        o.ph   = 2'((k / CD) % 4);
        if (k >= FR && j < CW) begin
            o.sync = (j == 0);
            o.ks   = fk[0][f][CW-1-j];
            o.kd   = fk[1][f][CW-1-j];
            o.kp   = fk[2][f][CW-1-j];
            o.kf   = fk[3][f][CW-1-j];
        end
        return o;
    endfunction

    task automatic check_out(input string name, input out_t act, input out_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got c192,c48,ph,sync,KsKdKpKf=%b want %b", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic clear_fk();
        for (int c = 0; c < 4; c++)
            for (int f = 0; f < 8; f++)
                fk[c][f] = '0;
    endtask

    task automatic set_fk(input int c, input int f0, input int f1, input logic [CW-1:0] v);
        for (int f = f0; f <= f1; f++) fk[c][f] = v;
    endtask

    task automatic do_reset();
        enable = 1'b0;
        cfg_we = 1'b0;
        reset  = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic write_cfg(input logic [1:0] sel, input logic [CW-1:0] d);
        cfg_we   = 1'b1;
        cfg_sel  = sel;
        cfg_data = d;
        @(posedge clock);
        #1;
        cfg_we = 1'b0;
    endtask

    // Per-scenario stimulus and extra checks, run after cycle k is compared
    task automatic hook(input int k);
        case (scen)
            1: begin
                for (int i = 0; i < 8; i++)
                    if (tv[i].cyc == k)
                        check_out($sformatf("table_c%0d", k), dut_out(), tv[i].exp);
            end
            2: begin
                if (k == 30) check_bit("pend_before_bnd", cfg_pending, 1'b1);
                if (k == 32) check_bit("pend_after_bnd", cfg_pending, 1'b0);
            end
            3: begin
                if (k == 31) begin
                    cfg_we = 1'b1; cfg_sel = 2'd1; cfg_data = 18'h3FFFF;
                end
                if (k == 32) begin
                    cfg_we = 1'b0;
                    check_bit("pend_collision", cfg_pending, 1'b1);
                end
                if (k == 63) check_bit("pend_hold_c63", cfg_pending, 1'b1);
                if (k == 64) check_bit("pend_clear_c64", cfg_pending, 1'b0);
                if (k == 69) begin
                    cfg_we = 1'b1; cfg_sel = 2'd2; cfg_data = 18'h0ABCD;
                end
                if (k == 70) begin
                    cfg_we = 1'b0;
                    check_bit("pend_midstream", cfg_pending, 1'b1);
                end
                if (k == 96) check_bit("pend_clear_c96", cfg_pending, 1'b0);
            end
            4: begin
                if (k == 41) enable = 1'b0;
            end
            default: ;
        endcase
    endtask

    // Scoreboard loop: expectation queued with the stimulus, popped at output
    task automatic run_cycles(input int n);
        out_t e;
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(model(k));
            @(posedge clock);
            #1;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL scoreboard_empty: got 0 entries want 1");
            end else begin
                e = exp_q.pop_front();
                check_out($sformatf("out_s%0d_c%0d", scen, k), dut_out(), e);
            end
            hook(k);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        tv[0] = '{0,  mk(1'b0, 1'b0, 2'd0, 1'b0)};
        tv[1] = '{7,  mk(1'b1, 1'b0, 2'd0, 1'b0)};
        tv[2] = '{8,  mk(1'b0, 1'b0, 2'd1, 1'b0)};
        tv[3] = '{15, mk(1'b1, 1'b0, 2'd1, 1'b0)};
        tv[4] = '{23, mk(1'b1, 1'b0, 2'd2, 1'b0)};
        tv[5] = '{24, mk(1'b0, 1'b0, 2'd3, 1'b0)};
        tv[6] = '{31, mk(1'b1, 1'b1, 2'd3, 1'b0)};
        tv[7] = '{32, mk(1'b0, 1'b0, 2'd0, 1'b1)};

        // Reset state
        reset = 1'b0;
        #12;
        check_out("reset_out", dut_out(), '0);
        check_bit("reset_pending", cfg_pending, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Divider timing with all-zero coefficients
        clear_fk();
        scen   = 1;
        enable = 1'b1;
        run_cycles(40);
        enable = 1'b0;
        @(posedge clock);
        #1;
        check_out("disable_out", dut_out(), '0);

        // Coefficient stream from values written in IDLE
        do_reset();
        clear_fk();
        write_cfg(2'd0, 18'h2AAAA);
        write_cfg(2'd3, 18'h00001);
        check_bit("pend_idle_write", cfg_pending, 1'b1);
        set_fk(0, 1, 2, 18'h2AAAA);
        set_fk(3, 1, 2, 18'h00001);
        scen   = 2;
        enable = 1'b1;
        run_cycles(86);

        // Boundary-collision write on Kd, mid-stream write on Kp
        do_reset();
        clear_fk();
        write_cfg(2'd1, 18'h12345);
        set_fk(1, 1, 1, 18'h12345);
        set_fk(1, 2, 3, 18'h3FFFF);
        set_fk(2, 3, 3, 18'h0ABCD);
        scen   = 3;
        enable = 1'b1;
        run_cycles(116);

        // Abort at stream bit 9, then re-enable
        do_reset();
        clear_fk();
        write_cfg(2'd0, 18'h2AAAA);
        write_cfg(2'd1, 18'h3FFFF);
        write_cfg(2'd2, 18'h0ABCD);
        write_cfg(2'd3, 18'h00001);
        set_fk(0, 1, 7, 18'h2AAAA);
        set_fk(1, 1, 7, 18'h3FFFF);
        set_fk(2, 1, 7, 18'h0ABCD);
        set_fk(3, 1, 7, 18'h00001);
        scen   = 4;
        enable = 1'b1;
        run_cycles(42);
        @(posedge clock);
        #1;
        check_out("abort_out", dut_out(), '0);
        scen   = 5;
        enable = 1'b1;
        run_cycles(52);

        // Asynchronous reset in the middle of a stream
        do_reset();
        clear_fk();
        write_cfg(2'd0, 18'h2AAAA);
        write_cfg(2'd3, 18'h3FFFF);
        set_fk(0, 1, 1, 18'h2AAAA);
        set_fk(3, 1, 1, 18'h3FFFF);
        scen   = 6;
        enable = 1'b1;
        run_cycles(37);
        #2;
        reset = 1'b0;
        #1;
        check_out("async_reset_out", dut_out(), '0);
        check_bit("async_reset_pending", cfg_pending, 1'b0);
        clear_fk();
        @(negedge clock);
        reset = 1'b1;
        scen  = 7;
        run_cycles(52);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fm_ctrl_sequencer.md
# fm_ctrl_sequencer

Timing and configuration controller for the stereo FM modulator datapath. It derives the 192 kHz and 48 kHz clock enables from the master clock, keeping the two phase-aligned. It holds the four modulator coefficients (Ks, Kd, Kp, Kf) in shadow and active registers and streams them bit-serially into the datapath once per 48 kHz frame. Coefficient updates apply only at frame boundaries, so the datapath never sees a partial coefficient change.

## Interface
- CLK_DIV, 512, master-clock cycles per 192 kHz period; legal when 4*CLK_DIV > COEF_W+1
- COEF_W, 18, coefficient width in bits
- clock  in  1  master clock; all logic on the rising edge
- reset  in  1  asynchronous, active-low; clears all state
- enable  in  1  run request; low holds the sequencer idle
- cfg_we  in  1  coefficient write strobe, single cycle
- cfg_sel  in  2  write target: 0=Ks, 1=Kd, 2=Kp, 3=Kf
- cfg_data  in  COEF_W  coefficient value
- cfg_pending  out  1  a shadow write is waiting for the next frame boundary
- clken192kHz  out  1  one-cycle enable at 192 kHz
- clken48kHz  out  1  one-cycle enable at 48 kHz, coincident with every 4th clken192kHz
- phase  out  2  192 kHz sub-frame index 0..3
- coef_sync  out  1  high during the MSB bit of each coefficient stream
- Ks, Kd, Kp, Kf  out  1 each  serial coefficient bits, MSB first

## Operation
- States:
  - IDLE: enable low.
  - RUN: enable high, not streaming.
  - STREAM: shifting, bit counter 0..COEF_W-1.
- IDLE→RUN when enable is sampled high. Any state→IDLE when enable is sampled low.
- Entering IDLE synchronously clears:
  - divider, phase, and bit counter
  - enables, coef_sync, and all K outputs
- Shadow and active registers keep their values across IDLE.
- Divider: cnt counts 0..CLK_DIV-1 in RUN/STREAM. clken192kHz=1 when cnt==CLK_DIV-1. phase increments on that cycle and wraps 3→0.
- clken48kHz=1 when cnt==CLK_DIV-1 and phase==3.
- Frame boundary, on the clken48kHz cycle:
  - All four active registers load from the shadow registers, using shadow values before that edge.
  - cfg_pending clears.
  - The state moves RUN→STREAM.
- STREAM:
  - Starts the cycle after clken48kHz.
  - Each of Ks/Kd/Kp/Kf outputs bit COEF_W-1-i of its active register on stream cycle i.
  - coef_sync=1 on cycle 0 only.
  - After COEF_W cycles, the state returns to RUN and the K outputs hold 0.
- Writes:
  - cfg_we updates shadow[cfg_sel] in any state, including IDLE, and sets cfg_pending.
  - A write on the same cycle as clken48kHz goes to shadow only. It applies at the following boundary, and cfg_pending stays 1.
  - Multiple writes before a boundary: the last value for each coefficient wins.
- The active registers never change during STREAM.

## Timing
- Reset values:
  - all outputs 0
  - state IDLE, cnt 0, phase 0
  - shadow and active registers 0
- Counting from the first edge with enable=1 as cycle 0:
  - clken192kHz is first asserted on cycle CLK_DIV-1.
  - clken48kHz is first asserted on cycle 4*CLK_DIV-1, then every 4*CLK_DIV cycles.
- Stream latency:
  - MSB on cycle 4*CLK_DIV (one cycle after clken48kHz).
  - LSB on cycle 4*CLK_DIV+COEF_W-1.
- Write-to-apply latency: from the write edge to the next clken48kHz edge, between 1 and 4*CLK_DIV cycles.
- Reset asserted mid-stream: all outputs go to 0 immediately, asynchronously, with no partial word completion.
- enable low mid-stream: outputs go to 0 on the next edge.

## Test plan
- Timing, CLK_DIV=8, COEF_W=18: reset, then enable=1.
  - clken192kHz on cycles 7, 15, 23, 31.
  - clken48kHz only on cycle 31; phase sequence 0,1,2,3,0.
- Coefficient stream: write Ks=18'h2AAAA, Kf=18'h00001 in IDLE, then enable.
  - From cycle 32, Ks serialises 1,0,1,0,…, and Kf is 0×17 then 1.
  - coef_sync is high only on cycle 32; cfg_pending clears at cycle 31.
- Boundary collision: write Kd=18'h3FFFF exactly on a clken48kHz cycle.
  - The stream that follows carries the old Kd.
  - The next frame carries 3FFFF; cfg_pending stays 1 until then.
- Mid-stream write: write Kp during stream bit 5.
  - The current Kp stream is unchanged.
  - The new value appears at the next frame.
- Abort: drop enable at stream bit 9.
  - All outputs are 0 on the next edge.
  - Re-enable: clken48kHz reappears 4*CLK_DIV-1 cycles later, with a full stream of the unchanged active values.
- Async reset mid-stream: outputs go to 0 without waiting for a clock edge. After release, all coefficient streams are 0.
